ctrl_mem_load: RTL and testbench

- Upstream loader and address owner for the convolution engine.
- Accepts AXI-stream X (input vector) and F (filter) samples and writes them into the X and F memories.
- Asserts conv_start once both memories are full.
- During convolution, hands its X/F address counters over to the load/increment controls driven by the output controller (ctrl_conv_output), and feeds fmem_addr back to it.
- Returns to loading on the conv_done pulse.

---
 rtl/ctrl_mem_load.sv | 118 +++++++++++
 tb/tb_ctrl_mem_load.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_mem_load.sv
// ctrl_mem_load: fills the X/F memories from AXI-stream and hands the address counters to the output controller.
// Optional build macro F_PERSIST_EN keeps the filter loaded across rounds.
`default_nettype none

module ctrl_mem_load #(
  parameter int DATA_W           = 8,
  parameter int X_MEM_SIZE       = 8,
  parameter int F_MEM_SIZE       = 4,
  parameter int X_MEM_ADDR_WIDTH = 3,
  parameter int F_MEM_ADDR_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           s_data_in_x,
  input  logic                        s_valid_x,
  output logic                        s_ready_x,
  input  logic [DATA_W-1:0]           s_data_in_f,
  input  logic                        s_valid_f,
  output logic                        s_ready_f,
  input  logic                        load_xaddr,
  input  logic [X_MEM_ADDR_WIDTH-1:0] load_xaddr_val,
  input  logic                        en_xaddr_incr,
  input  logic                        load_faddr,
  input  logic                        en_faddr_incr,
  input  logic                        conv_done,
  output logic [X_MEM_ADDR_WIDTH-1:0] xmem_addr,
  output logic                        xmem_wr_en,
  output logic [DATA_W-1:0]           xmem_wr_data,
  output logic [F_MEM_ADDR_WIDTH-1:0] fmem_addr,
  output logic                        fmem_wr_en,
  output logic [DATA_W-1:0]           fmem_wr_data,
  output logic                        conv_start
);

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    CONV = 1'b1
  } state_t;

  // Wrap points compared explicitly so non-power-of-two depths work.
  localparam logic [X_MEM_ADDR_WIDTH-1:0] X_LAST = X_MEM_ADDR_WIDTH'(X_MEM_SIZE - 1);
  localparam logic [F_MEM_ADDR_WIDTH-1:0] F_LAST = F_MEM_ADDR_WIDTH'(F_MEM_SIZE - 1);

  state_t state;
  logic   x_full;
  logic   f_full;

  assign s_ready_x    = (state == LOAD) && !x_full;
  assign s_ready_f    = (state == LOAD) && !f_full;
  assign xmem_wr_en   = s_valid_x && s_ready_x;
  assign fmem_wr_en   = s_valid_f && s_ready_f;
  assign xmem_wr_data = s_data_in_x;
  assign fmem_wr_data = s_data_in_f;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= LOAD;
      xmem_addr  <= '0;
      fmem_addr  <= '0;
      x_full     <= 1'b0;
      f_full     <= 1'b0;
      conv_start <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (xmem_wr_en) begin
            if (xmem_addr == X_LAST) begin
              x_full    <= 1'b1;
              xmem_addr <= '0;
            end else begin
              xmem_addr <= xmem_addr + 1'b1;
            end
          end
          if (fmem_wr_en) begin
            if (fmem_addr == F_LAST) begin
              f_full    <= 1'b1;
              fmem_addr <= '0;
            end else begin
              fmem_addr <= fmem_addr + 1'b1;
            end
          end
          // Writes are impossible once both are full, so the counters are already 0 here.
          if (x_full && f_full) begin
            state      <= CONV;
            conv_start <= 1'b1;
          end
        end
        CONV: begin
          if (conv_done) begin
            state      <= LOAD;
            conv_start <= 1'b0;
            x_full     <= 1'b0;
`ifndef F_PERSIST_EN
            f_full     <= 1'b0;
`endif
            xmem_addr  <= '0;
            fmem_addr  <= '0;
          end else begin
            if (load_xaddr) begin
              xmem_addr <= load_xaddr_val;
            end else if (en_xaddr_incr) begin
              xmem_addr <= (xmem_addr == X_LAST) ? '0 : xmem_addr + 1'b1;
            end
            if (load_faddr) begin
              fmem_addr <= '0;
            end else if (en_faddr_incr) begin
              fmem_addr <= (fmem_addr == F_LAST) ? '0 : fmem_addr + 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_mem_load.sv
// tb_ctrl_mem_load: table-driven check of ctrl_mem_load plus sequences for stalls, reset and (optionally) F_PERSIST_EN.
`default_nettype none

module tb_ctrl_mem_load;
  localparam int DW = 8, XS = 8, FS = 4, XAW = 3, FAW = 2;

`ifdef F_PERSIST_EN
  localparam bit PERSIST = 1'b1;
`else
  localparam bit PERSIST = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [DW-1:0]  s_data_in_x = '0, s_data_in_f = '0;
  logic           s_valid_x = 1'b0, s_valid_f = 1'b0;
  logic           s_ready_x, s_ready_f;
  logic           load_xaddr = 1'b0, en_xaddr_incr = 1'b0, load_faddr = 1'b0, en_faddr_incr = 1'b0;
  logic [XAW-1:0] load_xaddr_val = '0;
  logic           conv_done = 1'b0;
  logic [XAW-1:0] xmem_addr;
  logic [FAW-1:0] fmem_addr;
  logic           xmem_wr_en, fmem_wr_en, conv_start;
  logic [DW-1:0]  xmem_wr_data, fmem_wr_data;

  ctrl_mem_load #(
    .DATA_W(DW), .X_MEM_SIZE(XS), .F_MEM_SIZE(FS),
    .X_MEM_ADDR_WIDTH(XAW), .F_MEM_ADDR_WIDTH(FAW)
  ) dut (
    .clk(clk), .reset(reset),
    .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
    .load_xaddr(load_xaddr), .load_xaddr_val(load_xaddr_val), .en_xaddr_incr(en_xaddr_incr),
    .load_faddr(load_faddr), .en_faddr_incr(en_faddr_incr), .conv_done(conv_done),
    .xmem_addr(xmem_addr), .xmem_wr_en(xmem_wr_en), .xmem_wr_data(xmem_wr_data),
    .fmem_addr(fmem_addr), .fmem_wr_en(fmem_wr_en), .fmem_wr_data(fmem_wr_data),
    .conv_start(conv_start)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit ffull_m = 1'b0;

  typedef struct {
    logic vx; logic [DW-1:0] dx; logic vf; logic [DW-1:0] df;
    logic lx; logic [XAW-1:0] lxv; logic ex; logic lf; logic ef; logic done;
    logic [XAW-1:0] xa; logic [FAW-1:0] fa;
    logic wx; logic wf; logic rx; logic rf; logic st;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic vx, input logic [DW-1:0] dx, input logic vf,
                              input logic [DW-1:0] df, input logic lx, input logic [XAW-1:0] lxv,
                              input logic ex, input logic lf, input logic ef, input logic done,
                              input logic [XAW-1:0] xa, input logic [FAW-1:0] fa,
                              input logic wx, input logic wf, input logic rx, input logic rf,
                              input logic st);
    vec_t v;
    v.vx = vx; v.dx = dx; v.vf = vf; v.df = df; v.lx = lx; v.lxv = lxv; v.ex = ex;
    v.lf = lf; v.ef = ef; v.done = done; v.xa = xa; v.fa = fa; v.wx = wx; v.wf = wf;
    v.rx = rx; v.rf = rf; v.st = st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    s_valid_x = 1'b0; s_valid_f = 1'b0; load_xaddr = 1'b0; load_xaddr_val = '0;
    en_xaddr_incr = 1'b0; load_faddr = 1'b0; en_faddr_incr = 1'b0; conv_done = 1'b0;
  endtask

  // Streams X (with optional valid gaps) and optionally F until both memories are full,
  // then checks the LOAD->CONV handover timing.
  task automatic stream(input bit do_f, input int gap);
    int xc = 0, fc = 0, cyc = 0;
    bit ewx, ewf;
    while (!(xc == XS && ffull_m) && cyc < 200) begin
      @(negedge clk);
      s_valid_x   = (xc < XS) && ((gap == 0) || (cyc % gap != 0));
      s_data_in_x = DW'(8'hA0 + xc);
      s_valid_f   = do_f;
      s_data_in_f = DW'(8'h30 + fc);
      #1;
      ewx = s_valid_x && (xc < XS);
      ewf = s_valid_f && !ffull_m;
      chk("stream_xwr", xmem_wr_en, ewx);
      chk("stream_fwr", fmem_wr_en, ewf);
      chk("stream_rdyf", s_ready_f, !ffull_m);
      chk("stream_start", conv_start, 1'b0);
      if (ewx) chk("stream_xaddr", xmem_addr, xc);
      if (ewf) chk("stream_faddr", fmem_addr, fc);
      if (ewx) xc++;
      if (ewf) begin
        fc++;
        if (fc == FS) ffull_m = 1'b1;
      end
      cyc++;
    end
    if (cyc >= 200) chk("stream_timeout", 1'b1, 1'b0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("full_rdyx", s_ready_x, 1'b0);
    chk("full_start", conv_start, 1'b0);
    chk("full_xaddr", xmem_addr, 0);
    @(negedge clk);
    #1;
    chk("conv_start", conv_start, 1'b1);
    chk("conv_faddr", fmem_addr, 0);
  endtask

  task automatic finish_conv();
    @(negedge clk);
    conv_done = 1'b1; en_xaddr_incr = 1'b1;
    @(negedge clk);
    idle_inputs();
    if (!PERSIST) ffull_m = 1'b0;
    #1;
    chk("done_start", conv_start, 1'b0);
    chk("done_xaddr", xmem_addr, 0);
    chk("done_faddr", fmem_addr, 0);
    chk("done_rdyx", s_ready_x, 1'b1);
    chk("done_rdyf", s_ready_f, !ffull_m);
  endtask

  initial begin
    // Full round with valid held high, then address handover in CONV.
    for (int c = 0; c < 8; c++)
      tbl[c] = mk(1, DW'(c + 1), 1, DW'(c + 1), 0, 0, 0, 0, 0, 0,
                  XAW'(c), (c < 4) ? FAW'(c) : FAW'(0), 1, c < 4, 1, c < 4, 0);
    tbl[8]  = mk(1, 8'h09, 1, 8'h05, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[10] = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1);
    tbl[11] = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 0, 2, 2, 0, 0, 0, 0, 1);
    tbl[12] = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 0, 3, 3, 0, 0, 0, 0, 1);
    tbl[13] = mk(0, 8'h00, 0, 8'h00, 1, 1, 1, 1, 1, 0, 4, 0, 0, 0, 0, 0, 1);
    tbl[14] = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    tbl[15] = mk(0, 8'h00, 0, 8'h00, 1, 5, 1, 1, 1, 1, 0, 0, 0, 0, 1, !PERSIST, 0);
    tbl[16] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, !PERSIST, 0);

    idle_inputs();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_xaddr", xmem_addr, 0);
    chk("rst_faddr", fmem_addr, 0);
    chk("rst_rdyx", s_ready_x, 1'b1);
    chk("rst_rdyf", s_ready_f, 1'b1);
    chk("rst_wr", {xmem_wr_en, fmem_wr_en}, 2'b00);
    chk("rst_start", conv_start, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      s_valid_x = tbl[i].vx; s_data_in_x = tbl[i].dx;
      s_valid_f = tbl[i].vf; s_data_in_f = tbl[i].df;
      load_xaddr = tbl[i].lx; load_xaddr_val = tbl[i].lxv; en_xaddr_incr = tbl[i].ex;
      load_faddr = tbl[i].lf; en_faddr_incr = tbl[i].ef; conv_done = tbl[i].done;
      #1;
      chk($sformatf("v%0d_xaddr", i), xmem_addr, tbl[i].xa);
      chk($sformatf("v%0d_faddr", i), fmem_addr, tbl[i].fa);
      chk($sformatf("v%0d_xwr", i), xmem_wr_en, tbl[i].wx);
      chk($sformatf("v%0d_fwr", i), fmem_wr_en, tbl[i].wf);
      chk($sformatf("v%0d_rdyx", i), s_ready_x, tbl[i].rx);
      chk($sformatf("v%0d_rdyf", i), s_ready_f, tbl[i].rf);
      chk($sformatf("v%0d_start", i), conv_start, tbl[i].st);
      chk($sformatf("v%0d_xdata", i), xmem_wr_data, tbl[i].dx);
      chk($sformatf("v%0d_fdata", i), fmem_wr_data, tbl[i].df);
    end
    idle_inputs();
    ffull_m = PERSIST;

    // X stalls every third cycle so F finishes first.
    stream(1'b1, 3);
    finish_conv();

    // Reset after three X writes abandons the partial load.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_valid_x = 1'b1; s_data_in_x = DW'(8'hC0 + i);
      #1;
      chk("pre_rst_xaddr", xmem_addr, i);
    end
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    #1;
    chk("in_rst_xaddr", xmem_addr, 3);
    @(negedge clk);
    reset = 1'b1;
    ffull_m = 1'b0;
    #1;
    chk("post_rst_xaddr", xmem_addr, 0);
    chk("post_rst_rdyx", s_ready_x, 1'b1);
    chk("post_rst_rdyf", s_ready_f, 1'b1);
    chk("post_rst_start", conv_start, 1'b0);
    stream(1'b1, 0);
    finish_conv();

`ifdef F_PERSIST_EN
    // Filter stays resident: X-only round reaches CONV.
    stream(1'b0, 2);
    finish_conv();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
